// File: rtl/csr_diff_pkg.sv
// Shared constants for the CSR difftest collector: CSR index/address map,
// reset privilege, and the address-to-index lookup.
package csr_diff_pkg;

  localparam int NUM_CSR = 16;

  localparam logic [3:0] IDX_MSTATUS  = 4'd0;
  localparam logic [3:0] IDX_MEPC     = 4'd1;
  localparam logic [3:0] IDX_MTVAL    = 4'd2;
  localparam logic [3:0] IDX_MSCRATCH = 4'd3;
  localparam logic [3:0] IDX_MCAUSE   = 4'd4;
  localparam logic [3:0] IDX_MTVEC    = 4'd5;
  localparam logic [3:0] IDX_MIE      = 4'd6;
  localparam logic [3:0] IDX_MIP      = 4'd7;
  localparam logic [3:0] IDX_MEDELEG  = 4'd8;
  localparam logic [3:0] IDX_MIDELEG  = 4'd9;
  localparam logic [3:0] IDX_SEPC     = 4'd10;
  localparam logic [3:0] IDX_STVAL    = 4'd11;
  localparam logic [3:0] IDX_SSCRATCH = 4'd12;
  localparam logic [3:0] IDX_STVEC    = 4'd13;
  localparam logic [3:0] IDX_SATP     = 4'd14;
  localparam logic [3:0] IDX_SCAUSE   = 4'd15;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MEDELEG  = 12'h302;
  localparam logic [11:0] ADDR_MIDELEG  = 12'h303;
  localparam logic [11:0] ADDR_SEPC     = 12'h141;
  localparam logic [11:0] ADDR_STVAL    = 12'h143;
  localparam logic [11:0] ADDR_SSCRATCH = 12'h140;
  localparam logic [11:0] ADDR_STVEC    = 12'h105;
  localparam logic [11:0] ADDR_SATP     = 12'h180;
  localparam logic [11:0] ADDR_SCAUSE   = 12'h142;

  localparam logic [1:0] PRIV_RESET = 2'b11;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } csr_lookup_t;

  function automatic csr_lookup_t csr_lookup(input logic [11:0] addr);
    csr_lookup_t r;
    r.hit = 1'b1;
    r.idx = '0;
    case (addr)
      ADDR_MSTATUS:  r.idx = IDX_MSTATUS;
      ADDR_MEPC:     r.idx = IDX_MEPC;
      ADDR_MTVAL:    r.idx = IDX_MTVAL;
      ADDR_MSCRATCH: r.idx = IDX_MSCRATCH;
      ADDR_MCAUSE:   r.idx = IDX_MCAUSE;
      ADDR_MTVEC:    r.idx = IDX_MTVEC;
      ADDR_MIE:      r.idx = IDX_MIE;
      ADDR_MIP:      r.idx = IDX_MIP;
      ADDR_MEDELEG:  r.idx = IDX_MEDELEG;
      ADDR_MIDELEG:  r.idx = IDX_MIDELEG;
      ADDR_SEPC:     r.idx = IDX_SEPC;
      ADDR_STVAL:    r.idx = IDX_STVAL;
      ADDR_SSCRATCH: r.idx = IDX_SSCRATCH;
      ADDR_STVEC:    r.idx = IDX_STVEC;
      ADDR_SATP:     r.idx = IDX_SATP;
      ADDR_SCAUSE:   r.idx = IDX_SCAUSE;
      default:       r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/csr_snap_fifo.sv
// Two-entry snapshot FIFO. Handshake: an entry transfers out exactly on a
// cycle where o_valid && i_ready; o_data holds while o_valid && !i_ready.
module csr_snap_fifo #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;

  logic w_pop;
  logic w_push;

  assign o_full  = (r_count == 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign w_pop   = o_valid & i_ready;
  // A same-cycle pop makes room, so a full FIFO can still accept a push.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = o_valid ? r_mem[r_rptr] : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/csr_diff_collector.sv
// Shadows committed CSR writes and privilege changes, and emits a snapshot
// into a small FIFO on each retire boundary where something changed.
module csr_diff_collector
  import csr_diff_pkg::*;
#(
  parameter int CSR_W = 76,
  parameter int SEQ_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [11:0]              wr_addr,
  input  logic [CSR_W-1:0]         wr_data,
  input  logic                     priv_valid,
  input  logic [1:0]               priv_in,
  input  logic                     commit_valid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_priv,
  output logic [NUM_CSR*CSR_W-1:0] out_csrs,
  output logic [SEQ_W-1:0]         out_seq
);

  localparam int SNAP_W = 2 + NUM_CSR * CSR_W + SEQ_W;

  logic [CSR_W-1:0] r_csr [NUM_CSR];
  logic [1:0]       r_priv;
  logic [SEQ_W-1:0] r_seq;
  logic             r_dirty;

  csr_lookup_t              w_lookup;
  logic                     w_wr_hit;
  logic [NUM_CSR*CSR_W-1:0] w_csr_flat;
  logic [1:0]               w_priv_next;
  logic                     w_dirty_next;
  logic                     w_full;
  logic                     w_pop;
  logic                     w_push;
  logic [SNAP_W-1:0]        w_snap_in;
  logic [SNAP_W-1:0]        w_snap_out;

  // Same-cycle writes bypass into the snapshot, so the shadow's next value
  // doubles as the data pushed.
  always_comb begin
    w_lookup   = csr_lookup(wr_addr);
    w_wr_hit   = wr_valid & w_lookup.hit;
    w_csr_flat = '0;
    for (int k = 0; k < NUM_CSR; k++) begin
      w_csr_flat[k*CSR_W +: CSR_W] = (w_wr_hit && (w_lookup.idx == 4'(k))) ? wr_data : r_csr[k];
    end
    w_priv_next  = priv_valid ? priv_in : r_priv;
    w_dirty_next = r_dirty | w_wr_hit | priv_valid;
  end

  assign w_pop     = out_valid & out_ready;
  assign w_push    = commit_valid & w_dirty_next & (~w_full | w_pop);
  assign w_snap_in = {w_priv_next, w_csr_flat, r_seq};

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_CSR; k++) begin
        r_csr[k] <= '0;
      end
      r_priv  <= PRIV_RESET;
      r_seq   <= '0;
      r_dirty <= 1'b1;
    end else begin
      for (int k = 0; k < NUM_CSR; k++) begin
        r_csr[k] <= w_csr_flat[k*CSR_W +: CSR_W];
      end
      r_priv <= w_priv_next;
      // A commit refused by a full FIFO leaves dirty set so changes coalesce.
      if (w_push) begin
        r_seq   <= r_seq + SEQ_W'(1);
        r_dirty <= 1'b0;
      end else begin
        r_dirty <= w_dirty_next;
      end
    end
  end

  csr_snap_fifo #(
    .W (SNAP_W)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_data  (w_snap_in),
    .o_full  (w_full),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_snap_out)
  );

  assign out_priv = w_snap_out[SNAP_W-1 -: 2];
  assign out_csrs = w_snap_out[SEQ_W +: NUM_CSR*CSR_W];
  assign out_seq  = w_snap_out[SEQ_W-1:0];

endmodule

// File: tb/tb_csr_diff_collector.sv
// Bench for csr_diff_collector: reference shadow model plus a queue of
// expected snapshots, checked against the DUT head every cycle.
module tb_csr_diff_collector;

  localparam int CSR_W  = 76;
  localparam int SEQ_W  = 16;
  localparam int NUM    = 16;
  localparam int SNAP_W = 2 + NUM * CSR_W + SEQ_W;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   wr_valid;
  logic [11:0]            wr_addr;
  logic [CSR_W-1:0]       wr_data;
  logic                   priv_valid;
  logic [1:0]             priv_in;
  logic                   commit_valid;
  logic                   out_valid;
  logic                   out_ready;
  logic [1:0]             out_priv;
  logic [NUM*CSR_W-1:0]   out_csrs;
  logic [SEQ_W-1:0]       out_seq;

  always #5 clock = ~clock;

  csr_diff_collector #(
    .CSR_W (CSR_W),
    .SEQ_W (SEQ_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .priv_valid   (priv_valid),
    .priv_in      (priv_in),
    .commit_valid (commit_valid),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_priv     (out_priv),
    .out_csrs     (out_csrs),
    .out_seq      (out_seq)
  );

  // Reference model state
  logic [11:0]       addr_tab [NUM];
  logic [CSR_W-1:0]  m_csr [NUM];
  logic [1:0]        m_priv;
  logic [SEQ_W-1:0]  m_seq;
  logic              m_dirty;
  logic [SNAP_W-1:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int n_dut_pops = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [SNAP_W-1:0] pack_model();
    logic [NUM*CSR_W-1:0] flat;
    for (int k = 0; k < NUM; k++) flat[k*CSR_W +: CSR_W] = m_csr[k];
    return {m_priv, flat, m_seq};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM; k++) m_csr[k] = '0;
    m_priv  = 2'b11;
    m_seq   = '0;
    m_dirty = 1'b1;
    exp_q.delete();
  endtask

  // At the negedge: check DUT head against the expected queue, then advance model.
  task automatic check_and_model();
    logic [SNAP_W-1:0] h;
    chk("out_valid", out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      chk("out_priv", out_priv, h[SNAP_W-1 -: 2]);
      chk("out_seq", out_seq, h[SEQ_W-1:0]);
      for (int k = 0; k < NUM; k++)
        chk($sformatf("csr%0d", k), out_csrs[k*CSR_W +: CSR_W], h[SEQ_W + k*CSR_W +: CSR_W]);
    end
    if (out_valid && out_ready) n_dut_pops++;
    if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
    if (wr_valid) begin
      for (int k = 0; k < NUM; k++) begin
        if (addr_tab[k] == wr_addr) begin
          m_csr[k] = wr_data;
          m_dirty  = 1'b1;
        end
      end
    end
    if (priv_valid) begin
      m_priv  = priv_in;
      m_dirty = 1'b1;
    end
    if (commit_valid && m_dirty && exp_q.size() < 2) begin
      exp_q.push_back(pack_model());
      m_seq   = m_seq + 1'b1;
      m_dirty = 1'b0;
    end
  endtask

  task automatic step(input logic wv, input logic [11:0] addr, input logic [CSR_W-1:0] data,
                      input logic pv, input logic [1:0] pin, input logic cv, input logic rdy);
    wr_valid     = wv;
    wr_addr      = addr;
    wr_data      = data;
    priv_valid   = pv;
    priv_in      = pin;
    commit_valid = cv;
    out_ready    = rdy;
    @(negedge clock);
    check_and_model();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 12'h000, '0, 1'b0, 2'b00, 1'b0, rdy);
  endtask

  // Reset is asserted with junk traffic on the inputs, which must be dropped.
  task automatic do_reset();
    reset        = 1'b1;
    wr_valid     = 1'b1;
    wr_addr      = 12'h341;
    wr_data      = 76'hABCD;
    priv_valid   = 1'b1;
    priv_in      = 2'b01;
    commit_valid = 1'b1;
    out_ready    = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_priv", out_priv, 2'b00);
    chk("rst_seq", out_seq, 16'h0000);
    chk("rst_csrs_zero", {127'd0, (out_csrs == '0)}, 128'd1);
  endtask

  task automatic expect_head(input string tag, input logic [15:0] seq, input logic [1:0] priv,
                             input int idx, input logic [CSR_W-1:0] val);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_seq"}, out_seq, seq);
    chk({tag, "_priv"}, out_priv, priv);
    chk({tag, "_csr"}, out_csrs[idx*CSR_W +: CSR_W], val);
  endtask

  int pops0;

  initial begin
    addr_tab = '{12'h300, 12'h341, 12'h343, 12'h340, 12'h342, 12'h305, 12'h304, 12'h344,
                 12'h302, 12'h303, 12'h141, 12'h143, 12'h140, 12'h105, 12'h180, 12'h142};
    do_reset();

    // First commit after reset emits the initial state
    step(1'b0, 12'h000, '0, 1'b0, 2'b00, 1'b1, 1'b0);
    expect_head("init", 16'h0000, 2'b11, 0, '0);
    idle(1'b1);

    // mtvec write then commit; second clean commit pushes nothing
    step(1'b1, 12'h305, 76'h8000_0000, 1'b0, 2'b00, 1'b0, 1'b1);
    step(1'b0, 12'h000, '0, 1'b0, 2'b00, 1'b1, 1'b1);
    expect_head("mtvec", 16'h0001, 2'b11, 5, 76'h8000_0000);
    idle(1'b1);
    step(1'b0, 12'h000, '0, 1'b0, 2'b00, 1'b1, 1'b1);
    chk("clean_commit_no_push", out_valid, 1'b0);

    // Bypass: write, priv change and commit in one cycle
    step(1'b1, 12'h341, 76'h1234, 1'b1, 2'b01, 1'b1, 1'b0);
    expect_head("bypass", 16'h0002, 2'b01, 1, 76'h1234);
    idle(1'b1);
    step(1'b0, 12'h000, '0, 1'b0, 2'b00, 1'b1, 1'b1);
    chk("bypass_dirty_clear", out_valid, 1'b0);

    // Backpressure: three dirty commits, third coalesced
    step(1'b1, 12'h340, 76'hA, 1'b0, 2'b00, 1'b1, 1'b0);
    step(1'b1, 12'h340, 76'hB, 1'b0, 2'b00, 1'b1, 1'b0);
    step(1'b1, 12'h340, 76'hC, 1'b0, 2'b00, 1'b1, 1'b0);
    repeat (3) idle(1'b0);
    expect_head("hold", 16'h0003, 2'b01, 3, 76'hA);
    pops0 = n_dut_pops;
    step(1'b0, 12'h000, '0, 1'b0, 2'b00, 1'b1, 1'b1);
    expect_head("coal_b", 16'h0004, 2'b01, 3, 76'hB);
    idle(1'b1);
    expect_head("coal_c", 16'h0005, 2'b01, 3, 76'hC);
    repeat (3) idle(1'b1);
    chk("coal_pop_count", n_dut_pops - pops0, 3);

    // Full FIFO: pop and dirty commit in the same cycle
    step(1'b1, 12'h342, 76'h11, 1'b0, 2'b00, 1'b1, 1'b0);
    step(1'b1, 12'h342, 76'h22, 1'b0, 2'b00, 1'b1, 1'b0);
    pops0 = n_dut_pops;
    step(1'b1, 12'h342, 76'h33, 1'b0, 2'b00, 1'b1, 1'b1);
    expect_head("full_pop", 16'h0007, 2'b01, 4, 76'h22);
    repeat (4) idle(1'b1);
    chk("full_pop_count", n_dut_pops - pops0, 3);

    // Unmapped write is ignored: no push, no state change
    step(1'b1, 12'h7C0, {CSR_W{1'b1}}, 1'b0, 2'b00, 1'b1, 1'b1);
    idle(1'b1);
    chk("unmapped_no_push", out_valid, 1'b0);
    step(1'b0, 12'h000, '0, 1'b1, 2'b00, 1'b1, 1'b0);
    expect_head("unmapped", 16'h0009, 2'b00, 3, 76'hC);
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [11:0] a;
      a = ($urandom_range(0, 3) == 0) ? 12'($urandom) : addr_tab[$urandom_range(0, 15)];
      step(1'($urandom_range(0, 1)), a, CSR_W'({$urandom, $urandom, $urandom}),
           ($urandom_range(0, 3) == 0), 2'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) != 0));
    end
    repeat (3) idle(1'b1);

    // Sequence wrap
    while (m_seq != 16'hFFFF) step(1'b0, 12'h000, '0, 1'b1, 2'($urandom), 1'b1, 1'b1);
    repeat (3) idle(1'b1);
    step(1'b0, 12'h000, '0, 1'b1, 2'b10, 1'b1, 1'b0);
    expect_head("seq_ffff", 16'hFFFF, 2'b10, 0, m_csr[0]);
    idle(1'b1);
    step(1'b0, 12'h000, '0, 1'b1, 2'b00, 1'b1, 1'b0);
    expect_head("seq_wrap", 16'h0000, 2'b00, 0, m_csr[0]);
    idle(1'b1);

    // Reset mid-operation with a full FIFO
    step(1'b1, 12'h180, 76'h55, 1'b0, 2'b00, 1'b1, 1'b0);
    step(1'b1, 12'h180, 76'h66, 1'b0, 2'b00, 1'b1, 1'b0);
    do_reset();
    idle(1'b0);
    step(1'b0, 12'h000, '0, 1'b0, 2'b00, 1'b1, 1'b0);
    expect_head("post_rst", 16'h0000, 2'b11, 14, '0);
    expect_head("post_rst_mepc", 16'h0000, 2'b11, 1, '0);
    repeat (2) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
